// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Storage holds FIFO_DEPTH words and is never reset. Read and write pointers
// wrap naturally because FIFO_DEPTH is a power of two. A separate occupancy
// counter drives the full/empty flags, so both flags come from registers only.
module sync_fifo #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 16,
    localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clear,
    output logic [LB_FIFO_DEPTH:0]   count
);

    localparam logic [LB_FIFO_DEPTH:0] CNT_FULL = (LB_FIFO_DEPTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] wr_ptr;
    logic [LB_FIFO_DEPTH-1:0] rd_ptr;
    logic [LB_FIFO_DEPTH:0]   count_q;
    logic                     push;
    logic                     pop;

    // Flags and handshakes derive only from registered occupancy.
    always_comb begin
        in_ready  = (count_q != CNT_FULL);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = mem[rd_ptr];
        count     = count_q;
    end

    // Pointer and occupancy update; reset beats clear beats push/pop.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LB_FIFO_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LB_FIFO_DEPTH'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (LB_FIFO_DEPTH+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (LB_FIFO_DEPTH+1)'(1);
            end
        end
    end

    // Payload write; a push coinciding with reset or clear is dropped.
    always_ff @(posedge clk) begin
        if (push && !rstn && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized checks of sync_fifo against a
// queue-based reference model of FIFO occupancy and ordering.
module tb_sync_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           clear = 1'b0;
    logic [4:0]     count;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] model_q [$];

    sync_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Drive one clock of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic r, input logic c, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        bit do_push;
        bit do_pop;
        rstn = r; clear = c; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        if (r || c) begin
            model_q.delete();
        end else begin
            do_push = iv && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b count=%0d, want 1 0 0",
                     in_ready, out_valid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        vectors++;
        if (count !== 5'(DEPTH) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fill: count=%0d in_ready=%b out_valid=%b, want 16 0 1",
                     count, in_ready, out_valid);
        end
        vectors++;
        if (out_data !== model_q[0]) begin
            miscompares++;
            $display("FAIL fill_head: out_data=%h want %h", out_data, model_q[0]);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (model_q.size() == 0 || out_data !== model_q[0]) begin
                miscompares++;
                $display("FAIL drain[%0d]: out_data=%h want %h", i, out_data,
                         model_q.size() != 0 ? model_q[0] : 8'hxx);
            end
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        end
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] second;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        second = model_q[1];
        cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
        vectors++;
        if (count !== 5'd15 || out_data !== second || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_push_pop: count=%0d out_data=%h in_ready=%b, want 15 %h 1",
                     count, out_data, in_ready, second);
        end
        while (model_q.size() > 0) begin
            vectors++;
            if (out_data !== model_q[0]) begin
                miscompares++;
                $display("FAIL full_drain: out_data=%h want %h", out_data, model_q[0]);
            end
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (count !== 5'd5 || out_data !== model_q[0]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: count=%0d out_data=%h, want 5 %h",
                         i, count, out_data, model_q[0]);
            end
            cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
        end
        vectors++;
        if (count !== 5'd5) begin
            miscompares++;
            $display("FAIL back_to_back_end: count=%0d want 5", count);
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] d;
        while (model_q.size() < 7) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        while (model_q.size() > 7) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b1);
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        d = 8'($urandom);
        cycle(1'b0, 1'b0, 1'b1, d, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== d || count !== 5'd1) begin
            miscompares++;
            $display("FAIL fall_through: out_valid=%b out_data=%h count=%0d, want 1 %h 1",
                     out_valid, out_data, count, d);
        end
    endtask

    task automatic test_random();
        logic iv, ordy, clr;
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 45);
            clr  = ($urandom_range(0, 99) < 2);
            cycle(1'b0, clr, iv, 8'($urandom), ordy);
            vectors++;
            if (count !== 5'(model_q.size()) ||
                in_ready !== (model_q.size() != DEPTH) ||
                out_valid !== (model_q.size() != 0) ||
                (model_q.size() != 0 && out_data !== model_q[0])) begin
                miscompares++;
                $display("FAIL random[%0d]: count=%0d rdy=%b vld=%b data=%h, want count=%0d",
                         i, count, in_ready, out_valid, out_data, model_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        while (model_q.size() < 4) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
    endtask

    task automatic test_empty_pop();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_pop: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_back_to_back();
        test_clear();
        test_random();
        test_reset_mid();
        test_empty_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the number of entries; it SHALL be a power of two ≥ 2.
REQ-003 Local constant LB_FIFO_DEPTH SHALL equal $clog2(FIFO_DEPTH).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rstn, input, 1 bit: synchronous reset, active-high (1 = reset), sampled on the rising edge of clk.
REQ-006 Port in_data, input, DATA_WIDTH bits: write payload.
REQ-007 Port in_valid, input, 1 bit: write request.
REQ-008 Port in_ready, output, 1 bit: FIFO can accept a word.
REQ-009 Port out_data, output, DATA_WIDTH bits: head-of-queue word.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid word.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the head word.
REQ-012 Port clear, input, 1 bit: synchronous flush request.
REQ-013 Port count, output, LB_FIFO_DEPTH+1 bits: current occupancy, 0..FIFO_DEPTH.

Function
REQ-014 Storage SHALL be FIFO_DEPTH × DATA_WIDTH, addressed by write and read pointers of LB_FIFO_DEPTH bits that wrap from FIFO_DEPTH-1 to 0.
REQ-015 in_ready SHALL equal (count != FIFO_DEPTH), combinationally from registered state only, independent of out_ready.
REQ-016 out_valid SHALL equal (count != 0).
REQ-017 out_data SHALL present the entry at the read pointer combinationally (first-word fall-through), with no extra read latency.
REQ-018 Push SHALL occur when in_valid && in_ready: in_data is written at the write pointer and the write pointer increments.
REQ-019 Pop SHALL occur when out_valid && out_ready: the read pointer increments.
REQ-020 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or when neither occurs.
REQ-021 A word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the cycle after the push edge.
REQ-022 When full, in_valid SHALL be ignored and contents SHALL be unchanged, even if out_ready=1 in the same cycle.
REQ-023 When empty, out_ready SHALL be ignored and count SHALL remain 0.
REQ-024 Data SHALL leave in exact push order across pointer wrap-around.
REQ-025 clear=1 SHALL, at the next edge, zero both pointers and count, discarding any concurrent push or pop.
REQ-026 Priority SHALL be rstn > clear > push/pop.

Reset
REQ-027 While rstn=1 at a rising edge, the pointers and count SHALL become 0, giving in_ready=1, out_valid=0, count=0 after that edge.
REQ-028 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-029 Asserting reset mid-operation SHALL discard all stored words within one edge.

Verification
REQ-030 Hold rstn=1 for 100 cycles, then release -> in_ready=1, out_valid=0, count=0.
REQ-031 Push 16 random bytes on consecutive cycles (depth 16) -> count=16, in_ready=0, out_valid=1.
REQ-032 From full, hold out_ready=1 for 16 cycles -> out_data matches the pushed bytes in order each cycle; count reaches 0, out_valid=0, in_ready=1.
REQ-033 At full, drive in_valid=1 with out_ready=1 -> pop occurs, push rejected, count=15; the next word out is the second one pushed.
REQ-034 With count=5, hold push and pop active for 20 cycles -> count stays 5, order preserved across pointer wrap.
REQ-035 With count=7, assert clear=1 together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
